cpu_memory: RTL
===============

Name: cpu_memory

Overview:
Memory-access pipeline stage sitting between execute and writeback. It accepts one instruction per new tag from execute. It performs at most one load or store over a single-outstanding request/ready data bus, with byte-lane alignment and sign/zero extension. It then presents the result to writeback using the same tag-change protocol: new work whenever input tag differs from output tag.

Parameters:
RESET_VECTOR, 32'h0000_0000, reset value of o_pc_next

Ports:
i_clock  in  1  single clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_stall  in  1  downstream stall; no new result presented while high
i_tag  in  8  execute tag; differs from o_tag => new instruction pending
i_inst_rd  in  5  destination register index
i_rd  in  32  ALU result (non-memory instructions)
i_branch  in  1  branch taken flag, passed through
i_pc_next  in  32  next PC, passed through
i_mem_read  in  1  instruction is a load
i_mem_write  in  1  instruction is a store (never both with read)
i_mem_width  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as word)
i_mem_signed  in  1  load sign-extends when 1
i_mem_address  in  32  byte address
i_mem_wdata  in  32  store data, LSB-aligned
o_bus_request  out  1  bus request, held until ready
o_bus_rw  out  1  1=write, 0=read
o_bus_address  out  32  word-aligned address ({addr[31:2],2'b00})
o_bus_wdata  out  32  lane-replicated store data
o_bus_wmask  out  4  byte-lane write enables
i_bus_rdata  in  32  read data, valid with ready
i_bus_ready  in  1  one-cycle completion strobe
o_busy  out  1  registered; high while in BUS_WAIT or HOLD
o_fault  out  1  registered; high for the retired instruction if misaligned
o_tag  out  8  tag of result presented to writeback
o_inst_rd  out  5  destination register
o_rd  out  32  result value
o_branch  out  1  passed through
o_pc_next  out  32  passed through

Behaviour:
- Reset (async): state IDLE; all outputs 0; o_pc_next=RESET_VECTOR. Reset during BUS_WAIT drops o_bus_request immediately; transaction abandoned.
- Upstream holds all inputs stable until o_tag==i_tag.
- States: IDLE, BUS_WAIT, HOLD.
- IDLE, i_stall=0, i_tag!=o_tag:
  - Non-memory op: next edge registers pass-through outputs, o_rd=i_rd, o_fault=0, o_tag=i_tag. Latency 1 cycle.
  - Misaligned op (half with addr[0]=1, or word with addr[1:0]!=0): no bus access; retire in 1 cycle with o_rd=0, o_fault=1.
  - Aligned memory op: latch all inputs, assert o_bus_request/rw/address/wdata/wmask next edge, enter BUS_WAIT.
- IDLE, i_stall=1: no action; outputs held.
- BUS_WAIT: bus outputs stable. On i_bus_ready:
  - Drop request.
  - Capture the load result (extracted lane, extended) into an internal buffer; stores capture the latched i_rd.
  - If i_stall=0: retire on the same edge (update o_* and o_tag, o_fault=0) and go to IDLE. Otherwise go to HOLD.
- HOLD: on the first cycle with i_stall=0, retire from the buffer and go to IDLE.
- Ready with no request outstanding is ignored.
- Load extraction:
  - byte = rdata lane addr[1:0].
  - half = lane addr[1] (low/high 16).
  - Sign-extend if i_mem_signed, else zero-extend.
  - Word is unmodified.
- Store mask:
  - byte = 4'b0001<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - half = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{wdata[15:0]}}.
  - word = 4'b1111.
- o_tag changes at most once per instruction; back-to-back non-memory ops retire one per cycle.
- o_busy registered: set on entry to BUS_WAIT, cleared on the edge returning to IDLE.

Decomposition:
- Shared package cpu_pkg: width codes MEM_BYTE/MEM_HALF/MEM_WORD, state encoding, tag width 8.
- One combinational sub-module, cpu_memory_align: computes the load extract/extend and the store mask/wdata replication. It is reused later by a load/store unit.

Test Plan:
- ALU pass-through: tag 1->2, i_rd=32'h1234, non-mem → next cycle o_tag=2, o_rd=32'h1234, no o_bus_request.
- Signed byte load: addr=32'h103, rdata=32'h80FF_0000, signed → o_bus_address=32'h100; o_rd=32'hFFFF_FF80 the edge ready is sampled; repeat unsigned → 32'h0000_0080.
- Half store: addr=32'h202, wdata=32'hABCD → wmask=4'b1100, o_bus_wdata=32'hABCD_ABCD, o_bus_rw=1; after ready, o_tag advances.
- Stall on completion: i_stall=1 when ready arrives → o_tag unchanged, o_busy=1 (HOLD); drop stall → retire next edge with captured data.
- Misaligned word at 32'h301 → no request, o_fault=1, o_rd=0, o_tag advances in 1 cycle.
- Reset mid-BUS_WAIT: assert i_reset between edges → o_bus_request=0 immediately, o_tag=0, o_pc_next=RESET_VECTOR; a later ready is ignored.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU pipeline stages: memory width codes,
// memory-stage state encoding and the pipeline tag width.
package cpu_pkg;

   localparam int TAG_W = 8;

   localparam logic [1:0] MEM_BYTE = 2'd0;
   localparam logic [1:0] MEM_HALF = 2'd1;
   localparam logic [1:0] MEM_WORD = 2'd2;

   localparam logic [1:0] STATE_IDLE     = 2'd0;
   localparam logic [1:0] STATE_BUS_WAIT = 2'd1;
   localparam logic [1:0] STATE_HOLD     = 2'd2;

   // Halves need an even address, words (and the reserved code) a multiple of four.
   function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] addr_lo);
      logic result;
      result = 1'b0;
      case (width)
         MEM_BYTE: result = 1'b0;
         MEM_HALF: result = addr_lo[0];
         default:  result = (addr_lo != 2'b00);
      endcase
      return result;
   endfunction

endpackage

// File: rtl/cpu_memory_align.sv
// Byte-lane alignment helper: extracts and extends load data from a bus word,
// and builds the replicated store data plus byte write mask.
module cpu_memory_align
   import cpu_pkg::*;
(
   input  logic [1:0]  width,
   input  logic [1:0]  addr_lo,
   input  logic        is_signed,
   input  logic [31:0] rdata,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_data,
   output logic [3:0]  store_mask
);

   logic [7:0]  byte_val;
   logic [15:0] half_val;

   always_comb begin
      byte_val   = rdata[7:0];
      half_val   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      load_data  = rdata;
      store_data = wdata;
      store_mask = 4'b1111;

      case (addr_lo)
         2'd0:    byte_val = rdata[7:0];
         2'd1:    byte_val = rdata[15:8];
         2'd2:    byte_val = rdata[23:16];
         default: byte_val = rdata[31:24];
      endcase

      // The reserved width code falls through to full-word behaviour.
      case (width)
         MEM_BYTE: begin
            load_data  = {{24{is_signed & byte_val[7]}}, byte_val};
            store_data = {4{wdata[7:0]}};
            store_mask = 4'b0001 << addr_lo;
         end
         MEM_HALF: begin
            load_data  = {{16{is_signed & half_val[15]}}, half_val};
            store_data = {2{wdata[15:0]}};
            store_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            load_data  = rdata;
            store_data = wdata;
            store_mask = 4'b1111;
         end
      endcase
   end

endmodule

// File: rtl/cpu_memory.sv
// Memory-access pipeline stage: takes one instruction per new tag from execute,
// performs at most one bus load/store, and hands the result to writeback by tag change.
module cpu_memory
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
)
(
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_stall,
   input  logic [TAG_W-1:0] i_tag,
   input  logic [4:0]       i_inst_rd,
   input  logic [31:0]      i_rd,
   input  logic             i_branch,
   input  logic [31:0]      i_pc_next,
   input  logic             i_mem_read,
   input  logic             i_mem_write,
   input  logic [1:0]       i_mem_width,
   input  logic             i_mem_signed,
   input  logic [31:0]      i_mem_address,
   input  logic [31:0]      i_mem_wdata,
   output logic             o_bus_request,
   output logic             o_bus_rw,
   output logic [31:0]      o_bus_address,
   output logic [31:0]      o_bus_wdata,
   output logic [3:0]       o_bus_wmask,
   input  logic [31:0]      i_bus_rdata,
   input  logic             i_bus_ready,
   output logic             o_busy,
   output logic             o_fault,
   output logic [TAG_W-1:0] o_tag,
   output logic [4:0]       o_inst_rd,
   output logic [31:0]      o_rd,
   output logic             o_branch,
   output logic [31:0]      o_pc_next
);

   logic [1:0]       state;
   logic [TAG_W-1:0] lat_tag;
   logic [4:0]       lat_inst_rd;
   logic [31:0]      lat_rd;
   logic             lat_branch;
   logic [31:0]      lat_pc_next;
   logic             lat_read;
   logic [1:0]       lat_width;
   logic [1:0]       lat_addr_lo;
   logic             lat_signed;
   logic [31:0]      result_buf;

   logic [1:0]       align_width;
   logic [1:0]       align_addr_lo;
   logic             align_signed;
   logic [31:0]      load_data;
   logic [31:0]      store_data;
   logic [3:0]       store_mask;
   logic [31:0]      bus_result;
   logic             is_mem;
   logic             misaligned;

   // In IDLE the aligner prepares the store from live inputs; afterwards it decodes the load.
   assign align_width   = (state == STATE_IDLE) ? i_mem_width           : lat_width;
   assign align_addr_lo = (state == STATE_IDLE) ? i_mem_address[1:0]    : lat_addr_lo;
   assign align_signed  = (state == STATE_IDLE) ? i_mem_signed          : lat_signed;
   assign is_mem        = i_mem_read | i_mem_write;
   assign misaligned    = is_misaligned(i_mem_width, i_mem_address[1:0]);
   assign bus_result    = lat_read ? load_data : lat_rd;

   cpu_memory_align u_align (
      .width      (align_width),
      .addr_lo    (align_addr_lo),
      .is_signed  (align_signed),
      .rdata      (i_bus_rdata),
      .wdata      (i_mem_wdata),
      .load_data  (load_data),
      .store_data (store_data),
      .store_mask (store_mask)
   );

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state         <= STATE_IDLE;
         o_bus_request <= 1'b0;
         o_bus_rw      <= 1'b0;
         o_bus_address <= '0;
         o_bus_wdata   <= '0;
         o_bus_wmask   <= '0;
         o_busy        <= 1'b0;
         o_fault       <= 1'b0;
         o_tag         <= '0;
         o_inst_rd     <= '0;
         o_rd          <= '0;
         o_branch      <= 1'b0;
         o_pc_next     <= RESET_VECTOR;
         lat_tag       <= '0;
         lat_inst_rd   <= '0;
         lat_rd        <= '0;
         lat_branch    <= 1'b0;
         lat_pc_next   <= '0;
         lat_read      <= 1'b0;
         lat_width     <= '0;
         lat_addr_lo   <= '0;
         lat_signed    <= 1'b0;
         result_buf    <= '0;
      end else begin
         case (state)
            STATE_IDLE: begin
               if (!i_stall && (i_tag != o_tag)) begin
                  if (!is_mem || misaligned) begin
                     o_tag     <= i_tag;
                     o_inst_rd <= i_inst_rd;
                     o_rd      <= is_mem ? 32'h0 : i_rd;
                     o_fault   <= is_mem;
                     o_branch  <= i_branch;
                     o_pc_next <= i_pc_next;
                  end else begin
                     lat_tag       <= i_tag;
                     lat_inst_rd   <= i_inst_rd;
                     lat_rd        <= i_rd;
                     lat_branch    <= i_branch;
                     lat_pc_next   <= i_pc_next;
                     lat_read      <= i_mem_read;
                     lat_width     <= i_mem_width;
                     lat_addr_lo   <= i_mem_address[1:0];
                     lat_signed    <= i_mem_signed;
                     o_bus_request <= 1'b1;
                     o_bus_rw      <= i_mem_write;
                     o_bus_address <= {i_mem_address[31:2], 2'b00};
                     o_bus_wdata   <= store_data;
                     o_bus_wmask   <= i_mem_write ? store_mask : 4'b0000;
                     o_busy        <= 1'b1;
                     state         <= STATE_BUS_WAIT;
                  end
               end
            end

            STATE_BUS_WAIT: begin
               if (i_bus_ready) begin
                  o_bus_request <= 1'b0;
                  result_buf    <= bus_result;
                  if (!i_stall) begin
                     o_tag     <= lat_tag;
                     o_inst_rd <= lat_inst_rd;
                     o_rd      <= bus_result;
                     o_fault   <= 1'b0;
                     o_branch  <= lat_branch;
                     o_pc_next <= lat_pc_next;
                     o_busy    <= 1'b0;
                     state     <= STATE_IDLE;
                  end else begin
                     state     <= STATE_HOLD;
                  end
               end
            end

            STATE_HOLD: begin
               if (!i_stall) begin
                  o_tag     <= lat_tag;
                  o_inst_rd <= lat_inst_rd;
                  o_rd      <= result_buf;
                  o_fault   <= 1'b0;
                  o_branch  <= lat_branch;
                  o_pc_next <= lat_pc_next;
                  o_busy    <= 1'b0;
                  state     <= STATE_IDLE;
               end
            end

            default: state <= STATE_IDLE;
         endcase
      end
   end

endmodule
